// File: rtl/keypad_pkg.sv
// keypad_pkg: shared encodings for the keypad front end.
//   - key class encodings (digit / operator / equals / unmapped)
//   - operator value encodings
//   - keymap(): keycode -> {class, value} for the 4x4 calculator pad
package keypad_pkg;

    typedef enum logic [1:0] {
        KCLS_DIGIT = 2'd0,
        KCLS_OP    = 2'd1,
        KCLS_EQ    = 2'd2,
        KCLS_NONE  = 2'd3
    } kcls_e;

    localparam logic [3:0] OP_PLUS  = 4'd1;
    localparam logic [3:0] OP_MINUS = 4'd2;

    typedef struct packed {
        kcls_e      cls;
        logic [3:0] val;
    } kinfo_t;

    function automatic kinfo_t keymap(input int unsigned code);
        kinfo_t k;
        k.cls = KCLS_NONE;
        k.val = 4'd0;
        case (code)
            0:  begin k.cls = KCLS_DIGIT; k.val = 4'd1;     end
            1:  begin k.cls = KCLS_DIGIT; k.val = 4'd2;     end
            2:  begin k.cls = KCLS_DIGIT; k.val = 4'd3;     end
            3:  begin k.cls = KCLS_OP;    k.val = OP_PLUS;  end
            4:  begin k.cls = KCLS_DIGIT; k.val = 4'd4;     end
            5:  begin k.cls = KCLS_DIGIT; k.val = 4'd5;     end
            6:  begin k.cls = KCLS_DIGIT; k.val = 4'd6;     end
            7:  begin k.cls = KCLS_OP;    k.val = OP_MINUS; end
            8:  begin k.cls = KCLS_DIGIT; k.val = 4'd7;     end
            9:  begin k.cls = KCLS_DIGIT; k.val = 4'd8;     end
            10: begin k.cls = KCLS_DIGIT; k.val = 4'd9;     end
            13: begin k.cls = KCLS_DIGIT; k.val = 4'd0;     end
            15: begin k.cls = KCLS_EQ;    k.val = 4'd0;     end
            default: ;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/keypad_scan_fifo_fifo.sv
// sync_fifo: single-clock FIFO, power-of-two DEPTH.
//   push/din  : write when not full, or when full but popping this cycle
//   pop/dout  : dout is the registered head entry; pop ignored when empty
//   full/empty: occupancy flags
// Storage is reset so the head reads as zero out of reset.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/keypad_scan_fifo.sv
// keypad_scan_fifo: matrix keypad scanner with frame debounce, press-edge
// detection, ghost-key guard and an event FIFO toward the consumer.
//   clk, reset         : clock, synchronous active-high reset
//   cols               : one-hot column drive, held SCAN_DIV cycles each
//   rows               : raw row sense (asynchronous, active-high)
//   ev_valid/ev_ready  : event handshake, pop on valid && ready
//   ev_code/class/val  : head event (code = row*N_COLS + col)
//   keys_down          : debounced key map non-empty
//   overflow / ovf_clr : sticky drop flag and its clear (set wins)
module keypad_scan_fifo
    import keypad_pkg::*;
#(
    parameter int N_ROWS          = 4,
    parameter int N_COLS          = 4,
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 8,
    parameter int FIFO_DEPTH      = 4,
    localparam int KW             = $clog2(N_ROWS*N_COLS)
) (
    input  logic              clk,
    input  logic              reset,
    output logic [N_COLS-1:0] cols,
    input  logic [N_ROWS-1:0] rows,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [KW-1:0]     ev_code,
    output logic [1:0]        ev_class,
    output logic [3:0]        ev_val,
    output logic              keys_down,
    output logic              overflow,
    input  logic              ovf_clr
);
    localparam int NK  = N_ROWS*N_COLS;
    localparam int CW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CIW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam logic [7:0] DB = 8'(DEBOUNCE_FRAMES);

    typedef struct packed {
        logic [1:0]    cls;
        logic [3:0]    val;
        logic [KW-1:0] code;
    } ev_t;

    logic [N_ROWS-1:0] rows_s1, rows_s2;
    logic [CW-1:0]     dwell;
    logic [CIW-1:0]    col_idx;
    logic [NK-1:0]     snap, snap_nxt, prev_snap, stable_map, pending;
    logic [NK-1:0]     new_press, emit_oh;
    logic [7:0]        stable_cnt, stable_cnt_nxt;
    logic [KW-1:0]     emit_idx;
    logic              col_end, frame_end, db_update, emit;
    logic              fifo_full, fifo_empty, pop_fire, drop;
    int                pc;
    kinfo_t            info;
    ev_t               ev_in, head;

    always_comb begin
        col_end   = (dwell == CW'(SCAN_DIV-1));
        frame_end = col_end && (col_idx == CIW'(N_COLS-1));

        // Snapshot as it will look after this cycle's column sample, so the
        // frame-end compare sees the last column too.
        snap_nxt = snap;
        for (int r = 0; r < N_ROWS; r++)
            for (int c = 0; c < N_COLS; c++)
                if (col_end && col_idx == CIW'(c)) snap_nxt[r*N_COLS+c] = rows_s2[r];

        stable_cnt_nxt = stable_cnt;
        if (frame_end) begin
            if (snap_nxt != prev_snap) stable_cnt_nxt = 8'd0;
            else if (stable_cnt < DB)  stable_cnt_nxt = stable_cnt + 8'd1;
        end
        db_update = frame_end && (stable_cnt_nxt == DB) && (snap_nxt != stable_map);

        pc = 0;
        for (int i = 0; i < NK; i++) pc += int'(snap_nxt[i]);
        // More than two keys down can alias phantom keys: accept the map, emit nothing.
        new_press = (db_update && pc <= 2) ? (snap_nxt & ~stable_map) : '0;

        emit     = |pending;
        emit_oh  = pending & (~pending + NK'(1));
        emit_idx = '0;
        for (int i = NK-1; i >= 0; i--)
            if (pending[i]) emit_idx = KW'(i);
    end

    assign info     = keymap(32'(emit_idx));
    assign ev_in    = '{cls: info.cls, val: info.val, code: emit_idx};
    assign pop_fire = ev_ready && !fifo_empty;
    assign drop     = emit && fifo_full && !pop_fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            rows_s1    <= '0;
            rows_s2    <= '0;
            dwell      <= '0;
            col_idx    <= '0;
            cols       <= N_COLS'(1);
            snap       <= '0;
            prev_snap  <= '0;
            stable_cnt <= '0;
            stable_map <= '0;
            pending    <= '0;
            overflow   <= 1'b0;
        end else begin
            rows_s1 <= rows;
            rows_s2 <= rows_s1;
            snap    <= snap_nxt;
            if (col_end) begin
                dwell   <= '0;
                col_idx <= (col_idx == CIW'(N_COLS-1)) ? '0 : col_idx + 1'b1;
                cols    <= {cols[N_COLS-2:0], cols[N_COLS-1]};
            end else begin
                dwell <= dwell + 1'b1;
            end
            if (frame_end) prev_snap <= snap_nxt;
            stable_cnt <= stable_cnt_nxt;
            if (db_update) stable_map <= snap_nxt;
            pending <= (pending & ~emit_oh) | new_press;
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    sync_fifo #(.WIDTH($bits(ev_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (emit),
        .din   (ev_in),
        .full  (fifo_full),
        .pop   (pop_fire),
        .dout  (head),
        .empty (fifo_empty)
    );

    assign ev_valid  = !fifo_empty;
    assign ev_code   = head.code;
    assign ev_class  = head.cls;
    assign ev_val    = head.val;
    assign keys_down = |stable_map;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Bench for keypad_scan_fifo: 4x4 pad, SCAN_DIV=20, DEBOUNCE_FRAMES=3,
// FIFO_DEPTH=4. A key matrix model drives rows from cols; expected events
// are queued when keys are pressed and compared as the DUT hands them over.
module tb_keypad_scan_fifo;
    localparam int SD    = 20;
    localparam int DB    = 3;
    localparam int FD    = 4;
    localparam int FRAME = SD*4;

    logic       clk, reset, ev_valid, ev_ready, keys_down, overflow, ovf_clr;
    logic [3:0] cols, rows, ev_code, ev_val;
    logic [1:0] ev_class;
    logic [15:0] keys;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ev_count = 0;
    int exp_q[$];
    int pop_cyc[$];

    int exp_cls [16] = '{0,0,0,1, 0,0,0,1, 0,0,0,3, 3,0,3,2};
    int exp_val [16] = '{1,2,3,1, 4,5,6,2, 7,8,9,0, 0,0,0,0};

    keypad_scan_fifo #(
        .N_ROWS(4), .N_COLS(4), .SCAN_DIV(SD), .DEBOUNCE_FRAMES(DB), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .reset(reset), .cols(cols), .rows(rows),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
        .ev_class(ev_class), .ev_val(ev_val), .keys_down(keys_down),
        .overflow(overflow), .ovf_clr(ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Key matrix: a row reads high when any pressed key in it sits on the driven column.
    always_comb begin
        rows = '0;
        for (int r = 0; r < 4; r++) rows[r] = |(keys[r*4 +: 4] & cols);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted handshake must match the oldest expected event.
    always @(negedge clk) begin
        if (!reset && ev_valid && ev_ready) begin
            ev_count++;
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_event_code", {28'd0, ev_code}, 32'hFFFF_FFFF);
            end else begin
                int e;
                e = exp_q.pop_front();
                check("ev_code", {28'd0, ev_code}, e);
                check("ev_class", {30'd0, ev_class}, exp_cls[e]);
                check("ev_val", {28'd0, ev_val}, exp_val[e]);
            end
        end
    end

    initial begin
        logic [3:0] prev_cols, exp_cols;
        int n, base;
        int seq5 [5] = '{1, 2, 4, 6, 9};

        reset = 1'b1; keys = '0; ev_ready = 1'b0; ovf_clr = 1'b0;
        step(5);
        check("rst_cols", cols, 4'b0001);
        check("rst_ev_valid", ev_valid, 0);
        check("rst_ev_code", ev_code, 0);
        check("rst_ev_class", ev_class, 0);
        check("rst_ev_val", ev_val, 0);
        check("rst_keys_down", keys_down, 0);
        check("rst_overflow", overflow, 0);
        reset = 1'b0;

        // Column rotation and dwell with no keys.
        prev_cols = cols;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (cols == prev_cols && n < 4*SD) begin step(1); n++; end
            exp_cols = {prev_cols[2:0], prev_cols[3]};
            if (k > 0) check("col_dwell", n, SD);
            check("cols_seq", cols, exp_cols);
            prev_cols = cols;
        end
        check("idle_ev_valid", ev_valid, 0);
        check("idle_keys_down", keys_down, 0);

        // Single held key (row1, col1), release produces nothing.
        ev_ready = 1'b1;
        base = ev_count;
        keys[5] = 1'b1; exp_q.push_back(5);
        step(10*FRAME);
        check("hold_one_event", ev_count, base + 1);
        check("hold_keys_down", keys_down, 1);
        keys = '0;
        step(6*FRAME);
        check("release_keys_down", keys_down, 0);
        check("release_no_event", ev_count, base + 1);

        // Chatter on key 0, then a steady hold.
        base = ev_count;
        for (int i = 0; i < 20; i++) begin
            keys[0] = ~keys[0];
            step(FRAME);
        end
        check("chatter_no_event", ev_count, base);
        keys[0] = 1'b1; exp_q.push_back(0);
        step(6*FRAME);
        check("chatter_hold_event", ev_count, base + 1);
        keys = '0;
        step(6*FRAME);

        // Two keys in one frame: serialised lowest code first, back to back.
        base = ev_count;
        keys[3] = 1'b1; keys[15] = 1'b1;
        exp_q.push_back(3); exp_q.push_back(15);
        step(6*FRAME);
        check("dual_events", ev_count, base + 2);
        if (pop_cyc.size() >= 2)
            check("dual_consecutive", pop_cyc[pop_cyc.size()-1] - pop_cyc[pop_cyc.size()-2], 1);
        keys = '0;
        step(6*FRAME);

        // Consumer stalled: five presses into a four-entry FIFO.
        ev_ready = 1'b0;
        base = ev_count;
        for (int i = 0; i < 5; i++) begin
            keys[seq5[i]] = 1'b1;
            if (i < FD) exp_q.push_back(seq5[i]);
            step(6*FRAME);
            keys = '0;
            step(6*FRAME);
            if (i == FD-1) check("full_no_overflow", overflow, 0);
        end
        check("overflow_set", overflow, 1);
        check("stall_valid", ev_valid, 1);
        check("stall_head_stable", ev_code, 1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        check("overflow_cleared", overflow, 0);
        ev_ready = 1'b1;
        step(10);
        check("drain_count", ev_count, base + FD);
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_empty", ev_valid, 0);

        // Ghost guard: three keys give no event; once the map is back to one
        // held key, a new key in an already-scanned column registers normally.
        base = ev_count;
        keys[0] = 1'b1; keys[1] = 1'b1; keys[2] = 1'b1;
        step(6*FRAME);
        check("ghost_no_event", ev_count, base);
        check("ghost_keys_down", keys_down, 1);
        keys[2] = 1'b0;
        step(6*FRAME);
        check("ghost_release_no_event", ev_count, base);
        keys[1] = 1'b0; keys[5] = 1'b1; exp_q.push_back(5);
        step(6*FRAME);
        check("ghost_new_key_event", ev_count, base + 1);
        keys = '0;
        step(6*FRAME);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_overflow", overflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scan_fifo.md
Name: keypad_scan_fifo

Overview:
- Parametrised matrix-keypad scanner for the calculator front end: N_ROWS x N_COLS, per-frame debounce, press-edge detection, ghost-key guard.
- Decoded key events go into a small FIFO with a valid/ready handshake toward the calculator control FSM.
- Key presses are no longer lost when the consumer is busy, and simultaneous presses are serialised.

Parameters:
- N_ROWS, 4, number of row inputs sensed.
- N_COLS, 4, number of column outputs driven.
- SCAN_DIV, 1000, clk cycles each column is held active; must be >= N_ROWS*N_COLS+1.
- DEBOUNCE_FRAMES, 8, consecutive identical full-frame snapshots required before the stable key map updates (1..255).
- FIFO_DEPTH, 4, event FIFO entries (power of two, >= 2).
- KW, $clog2(N_ROWS*N_COLS), keycode width (derived, not overridable).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- cols  out  N_COLS  one-hot active-high column drive.
- rows  in  N_ROWS  raw asynchronous row sense, active-high.
- ev_valid  out  1  FIFO head holds an event.
- ev_ready  in  1  consumer accepts the head event this cycle.
- ev_code  out  KW  keycode = row*N_COLS + col.
- ev_class  out  2  0 digit, 1 operator, 2 equals, 3 unmapped.
- ev_val  out  4  BCD digit for class 0; op code (1 plus, 2 minus) for class 1; 0 otherwise.
- keys_down  out  1  stable map non-empty.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- ovf_clr  in  1  clears overflow.

Behaviour:
- Reset values: cols = 1 (column 0), ev_valid = 0, ev_code/ev_class/ev_val = 0, keys_down = 0, overflow = 0. All counters, snapshots, the stable map, the pending mask and the FIFO are cleared. Reset mid-frame discards the partial frame.
- rows pass through a 2-flop synchroniser.
- Column dwell counter runs 0..SCAN_DIV-1. At count SCAN_DIV-1:
  - synchronised rows are written to snapshot bits [r*N_COLS+c];
  - cols rotates left, with wrap from column N_COLS-1 to column 0.
- Frame end = sample of the last column. At frame end:
  - if snapshot == previous snapshot, stable_cnt increments, saturating at DEBOUNCE_FRAMES; otherwise stable_cnt = 0;
  - previous snapshot <= snapshot.
- When stable_cnt reaches DEBOUNCE_FRAMES and snapshot != stable map:
  - new_press = snapshot & ~stable map;
  - stable map <= snapshot;
  - pending mask |= new_press.
- Ghost guard: if popcount(snapshot) > 2, the stable map still updates but new_press is forced to 0.
- Releases never generate events.
- Emitter: each cycle with pending != 0, the lowest set index is pushed and its pending bit is cleared. This is one event per cycle, and all pending events are drained well before the next frame end by the SCAN_DIV constraint.
- If the FIFO is full, the event is dropped, its pending bit is still cleared, and overflow is set.
- Push and pop in the same cycle while the FIFO is full: the pop frees the slot, so the push succeeds.
- ovf_clr in the same cycle as a new drop: overflow stays 1 (set wins).
- Handshake:
  - pop when ev_valid && ev_ready;
  - outputs are registered from the FIFO head, with latency 1 cycle from push to ev_valid;
  - ev_code/ev_class/ev_val are stable while ev_valid && !ev_ready;
  - ev_ready with an empty FIFO has no effect.
- Keymap for 4x4, code -> class/val:
  - 0->1, 1->2, 2->3, 3->plus;
  - 4->4, 5->5, 6->6, 7->minus;
  - 8->7, 9->8, 10->9, 11->unmapped;
  - 12->unmapped, 13->0, 14->unmapped, 15->equals.
- Codes outside the table map to class 3.

Decomposition:
- keypad_pkg holds:
  - class encodings (KCLS_DIGIT, KCLS_OP, KCLS_EQ, KCLS_NONE);
  - op encodings (OP_PLUS=1, OP_MINUS=2);
  - keymap function code -> {class, val}.
- Sub-module sync_fifo (parametrised WIDTH, DEPTH) with push/full/pop/empty.
- Scanner, debounce and emitter stay in the top module.

Test Plan:
- Reset release, no keys, SCAN_DIV=4 -> cols cycles 0001,0010,0100,1000,0001 every 4 clk; ev_valid stays 0; keys_down 0.
- Hold row1 during column 1 for 10 frames, DEBOUNCE_FRAMES=3 -> exactly one event, code 5, class 0, val 5; keys_down=1 until release is stable; release produces no event.
- Chatter: toggle row0 every frame for 20 frames, then hold -> no event during chatter; one event (code 0, class 0, val 1) 3 stable frames after hold begins.
- Press codes 3 and 15 in the same frame with ev_ready=1 -> two events on consecutive cycles, code 3 (class 1, val 1) then code 15 (class 2, val 0).
- ev_ready=0, FIFO_DEPTH=4, press 5 distinct keys sequentially -> 4 events held, overflow=1. ovf_clr clears it. Draining yields the first 4 codes in order.
- Three keys pressed simultaneously -> no events (ghost guard). Releasing one of them then pressing a new key -> the new key's event is emitted normally.
